// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit storage/shift element with complementary outputs.
// Each enabled rising edge applies one of eight operations selected by mode:
// hold, load, shift left/right with serial input, rotate left/right, clear, invert.
// sout keeps the last bit shifted or rotated out; changed flags a value change.
module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout,
    output logic             changed
);

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'b000,
        MODE_LOAD   = 3'b001,
        MODE_SHL    = 3'b010,
        MODE_SHR    = 3'b011,
        MODE_ROTL   = 3'b100,
        MODE_ROTR   = 3'b101,
        MODE_CLEAR  = 3'b110,
        MODE_INVERT = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qbar_q, qbar_d;
    logic             sout_q, sout_d;
    logic             changed_q, changed_d;

    // Next-state selection; en=0 falls through to hold with sout untouched.
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        if (en) begin
            case (mode_e'(mode))
                MODE_HOLD:   q_d = q_q;
                MODE_LOAD:   q_d = d;
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], sin};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d    = {sin, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                MODE_ROTL: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_ROTR: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                // Clear goes to all zeros, deliberately not to RESET_VAL.
                MODE_CLEAR:  q_d = {WIDTH{1'b0}};
                MODE_INVERT: q_d = ~q_q;
                default:     q_d = q_q;
            endcase
        end
        // Value comparison, so a same-value load or rotate of a uniform word reads as no change.
        changed_d = (q_d != q_q);
        // qbar is registered from the same next-state so it never lags q.
        qbar_d    = ~q_d;
    end

    // State registers; reset forces outputs immediately without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q       <= RESET_VAL;
            qbar_q    <= ~RESET_VAL;
            sout_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            qbar_q    <= qbar_d;
            sout_q    <= sout_d;
            changed_q <= changed_d;
        end
    end

    assign q       = q_q;
    assign qbar    = qbar_q;
    assign sout    = sout_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: an 8-bit instance (RESET_VAL=8'hA5) and a 2-bit
// instance (RESET_VAL=2'b01) share stimulus and are compared against an
// arithmetic reference model after every edge, plus directed constant checks.
module tb_universal_shift_reg;

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                           ROTL = 3'd4, ROTR = 3'd5, CLR = 3'd6, INV = 3'd7;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [2:0] mode  = HOLD;
    logic [7:0] d     = 8'h00;
    logic       sin   = 1'b0;

    logic [7:0] q8, qb8;
    logic       so8, ch8;
    logic [1:0] q2, qb2;
    logic       so2, ch2;

    int n_vec = 0;
    int n_err = 0;

    int unsigned m8_q, m8_so, m8_ch;
    int unsigned m2_q, m2_so, m2_ch;

    universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q8), .qbar(qb8), .sout(so8), .changed(ch8)
    );

    universal_shift_reg #(.WIDTH(2), .RESET_VAL(2'b01)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d[1:0]), .sin(sin),
        .q(q2), .qbar(qb2), .sout(so2), .changed(ch2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference next value of a w-bit word, computed with integer arithmetic.
    function automatic int unsigned ref_next(int w, int unsigned q, int m, int unsigned dv, int unsigned s);
        int unsigned full;
        int unsigned top;
        full = 32'd1 << w;
        top  = q >> (w - 1);
        case (m)
            1:       return dv % full;
            2:       return (q * 2 + s) % full;
            3:       return q / 2 + s * (full / 2);
            4:       return (q * 2 + top) % full;
            5:       return q / 2 + (q % 2) * (full / 2);
            6:       return 0;
            7:       return full - 1 - q;
            default: return q;
        endcase
    endfunction

    function automatic int unsigned ref_sout(int w, int unsigned q, int m, int unsigned old);
        if (m == 2 || m == 4) return q >> (w - 1);
        if (m == 3 || m == 5) return q % 2;
        return old;
    endfunction

    task automatic model_reset();
        m8_q = 32'hA5; m8_so = 0; m8_ch = 0;
        m2_q = 32'h1;  m2_so = 0; m2_ch = 0;
    endtask

    task automatic model_edge();
        int unsigned n;
        if (!rst_n) begin
            model_reset();
        end else begin
            n = en ? ref_next(8, m8_q, int'(mode), 32'(d), 32'(sin)) : m8_q;
            if (en) m8_so = ref_sout(8, m8_q, int'(mode), m8_so);
            m8_ch = (n != m8_q) ? 1 : 0;
            m8_q  = n;
            n = en ? ref_next(2, m2_q, int'(mode), 32'(d) % 4, 32'(sin)) : m2_q;
            if (en) m2_so = ref_sout(2, m2_q, int'(mode), m2_so);
            m2_ch = (n != m2_q) ? 1 : 0;
            m2_q  = n;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q8"},    32'(q8),  m8_q);
        check({tag, ".qb8"},   32'(qb8), 255 - m8_q);
        check({tag, ".sout8"}, 32'(so8), m8_so);
        check({tag, ".chg8"},  32'(ch8), m8_ch);
        check({tag, ".q2"},    32'(q2),  m2_q);
        check({tag, ".qb2"},   32'(qb2), 3 - m2_q);
        check({tag, ".sout2"}, 32'(so2), m2_so);
        check({tag, ".chg2"},  32'(ch2), m2_ch);
    endtask

    task automatic step(input string tag, input logic e, input logic [2:0] m,
                        input logic [7:0] dv, input logic s);
        en = e; mode = m; d = dv; sin = s;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b1011_0010;
        model_reset();

        // Asynchronous reset: assert mid-cycle, values appear before any edge.
        rst_n = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_q", 32'(q8), 32'hA5);
        check("rst_async_qbar", 32'(qb8), 32'h5A);
        check_all("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_hold");
        rst_n = 1'b1;

        step("hold", 1'b1, HOLD, 8'h00, 1'b0);
        check("hold_q", 32'(q8), 32'hA5);
        check("hold_chg", 32'(ch8), 32'h0);

        // Two-bit instance: SHL sin=1 then ROTR of 2'b11.
        step("w2_shl", 1'b1, SHL, 8'h00, 1'b1);
        check("w2_shl_q", 32'(q2), 32'h3);
        step("w2_rotr", 1'b1, ROTR, 8'h00, 1'b0);
        check("w2_rotr_q", 32'(q2), 32'h3);
        check("w2_rotr_chg", 32'(ch2), 32'h0);

        step("load3c", 1'b1, LOAD, 8'h3C, 1'b0);
        step("shl", 1'b1, SHL, 8'h00, 1'b1);
        check("shl_q", 32'(q8), 32'h79);
        check("shl_sout", 32'(so8), 32'h0);
        check("shl_chg", 32'(ch8), 32'h1);
        step("shr", 1'b1, SHR, 8'h00, 1'b0);
        check("shr_q", 32'(q8), 32'h3C);
        check("shr_sout", 32'(so8), 32'h1);

        step("load81", 1'b1, LOAD, 8'h81, 1'b0);
        step("rotl1", 1'b1, ROTL, 8'h00, 1'b0);
        check("rotl1_q", 32'(q8), 32'h03);
        check("rotl1_sout", 32'(so8), 32'h1);
        for (int i = 1; i < 8; i++) step("rotl", 1'b1, ROTL, 8'h00, 1'b0);
        check("rotl_wrap_q", 32'(q8), 32'h81);
        step("rotr", 1'b1, ROTR, 8'h00, 1'b0);
        check("rotr_q", 32'(q8), 32'hC0);

        step("loadf0", 1'b1, LOAD, 8'hF0, 1'b0);
        step("inv", 1'b1, INV, 8'h00, 1'b0);
        check("inv_q", 32'(q8), 32'h0F);
        step("clr", 1'b1, CLR, 8'h00, 1'b0);
        check("clr_q", 32'(q8), 32'h00);
        check("clr_chg", 32'(ch8), 32'h1);
        step("clr2", 1'b1, CLR, 8'h00, 1'b0);
        check("clr2_chg", 32'(ch8), 32'h0);
        step("en0", 1'b0, LOAD, 8'hFF, 1'b1);
        check("en0_q", 32'(q8), 32'h00);

        for (int i = 0; i < 8; i++) step("fill", 1'b1, SHL, 8'h00, pat[7-i]);
        check("fill_q", 32'(q8), 32'hB2);

        // Reset in the middle of a serial fill abandons it.
        step("fill_clr", 1'b1, CLR, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step("fill2", 1'b1, SHL, 8'h00, pat[7-i]);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_q", 32'(q8), 32'hA5);
        check_all("midrst");
        for (int i = 5; i < 8; i++) begin
            step("rst_ign", 1'b1, SHL, 8'h00, pat[7-i]);
            check("rst_ign_q", 32'(q8), 32'hA5);
        end
        rst_n = 1'b1;

        step("load5a", 1'b1, LOAD, 8'h5A, 1'b0);
        step("load5a_same", 1'b1, LOAD, 8'h5A, 1'b0);
        check("same_load_chg", 32'(ch8), 32'h0);
        step("loadff", 1'b1, LOAD, 8'hFF, 1'b0);
        step("rotl_ff", 1'b1, ROTL, 8'h00, 1'b0);
        check("rotl_ff_chg", 32'(ch8), 32'h0);
        step("load55", 1'b1, LOAD, 8'h55, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step("rotl55", 1'b1, ROTL, 8'h00, 1'b0);
            check("rotl55_chg", 32'(ch8), 32'h1);
        end

        // Randomized operation mix with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all("rnd_rst");
                step("rnd_rst_edge", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     8'($urandom), 1'($urandom_range(0, 1)));
                rst_n = 1'b1;
            end else begin
                step("rnd", 1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
                     8'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
